// File: rtl/ddr3_pkg.sv
// ddr3_pkg: shared types, command encodings and helpers for the DDR3 init sequencer.
package ddr3_pkg;

    localparam int DEF_BA_BITS   = 3;
    localparam int DEF_ADDR_BITS = 14;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_ZQCL = 4'b0110;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_DES  = 4'b1111;

    typedef enum logic [3:0] {
        S_IDLE, S_RST_HOLD, S_CKE_WAIT, S_XPR, S_MRS, S_WAIT_MRD, S_WAIT_MOD,
        S_ZQCL, S_WAIT_ZQ, S_DONE, S_PRE, S_WAIT_RP, S_REF, S_WAIT_RFC
    } init_state_t;

    function automatic int cyc(int t);
        return (t < 1) ? 1 : t;
    endfunction

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

    // MRS issue order MR2, MR3, MR1, MR0 mapped from the 2-bit sequence index
    function automatic logic [1:0] mr_num(logic [1:0] i);
        return {~i[1], i[1] ^ i[0]};
    endfunction

endpackage

// File: rtl/ddr3_wait_cnt.sv
// ddr3_wait_cnt: loadable down-counter that stops at zero and flags it.
module ddr3_wait_cnt #(
    parameter int W = 8
) (
    input  logic         ck,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ddr3_init_seq.sv
// ddr3_init_seq: DDR3 power-up/init sequencer driving the DRAM command pins.
// Optional periodic refresh handshake in DONE when DDR3_AUTO_REFRESH_EN is defined.
module ddr3_init_seq
    import ddr3_pkg::*;
#(
    parameter int BA_BITS      = DEF_BA_BITS,
    parameter int ADDR_BITS    = DEF_ADDR_BITS,
    parameter int T_RESET_CYC  = 160000,
    parameter int T_CKE_CYC    = 400000,
    parameter int T_XPR_CYC    = 96,
    parameter int T_MRD_CYC    = 4,
    parameter int T_MOD_CYC    = 12,
    parameter int T_ZQINIT_CYC = 512,
    parameter logic [ADDR_BITS-1:0] MR0_VAL = '0,
    parameter logic [ADDR_BITS-1:0] MR1_VAL = '0,
    parameter logic [ADDR_BITS-1:0] MR2_VAL = '0,
    parameter logic [ADDR_BITS-1:0] MR3_VAL = '0
`ifdef DDR3_AUTO_REFRESH_EN
    ,
    parameter int T_REFI_CYC   = 6240,
    parameter int T_RP_CYC     = 11,
    parameter int T_RFC_CYC    = 88
`endif
) (
    input  logic                 ck,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 init_done,
    output logic                 busy,
    output logic                 mem_rst_n,
    output logic                 cke,
    output logic                 cs_n,
    output logic                 ras_n,
    output logic                 cas_n,
    output logic                 we_n,
    output logic [BA_BITS-1:0]   ba,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 odt,
    output logic                 ref_req,
    input  logic                 ref_ack
);
`ifdef DDR3_AUTO_REFRESH_EN
    localparam int MAXR = max2(cyc(T_REFI_CYC), max2(cyc(T_RP_CYC), cyc(T_RFC_CYC)));
`else
    localparam int MAXR = 1;
`endif
    localparam int MAXT = max2(max2(max2(cyc(T_RESET_CYC), cyc(T_CKE_CYC)), max2(cyc(T_XPR_CYC), cyc(T_MRD_CYC))),
                               max2(max2(cyc(T_MOD_CYC), cyc(T_ZQINIT_CYC)), MAXR));
    localparam int CW = $clog2(MAXT + 1);
    localparam logic [ADDR_BITS-1:0] A10 = ADDR_BITS'(1 << 10);

    init_state_t          state, nxt;
    logic [1:0]           mr_idx, mr_nxt, mr_sel;
    logic                 load, zero, done_d, mem_rst_d, cke_d;
    logic [CW-1:0]        lval;
    logic [3:0]           cmd_d;
    logic [BA_BITS-1:0]   ba_d;
    logic [ADDR_BITS-1:0] addr_d;

    ddr3_wait_cnt #(.W(CW)) u_wait (.ck, .rst_n, .load, .load_val(lval), .zero);

    always_comb begin
        nxt = state;
        mr_nxt = mr_idx;
        case (state)
            S_IDLE:     if (start) nxt = S_RST_HOLD;
            S_RST_HOLD: if (zero) nxt = S_CKE_WAIT;
            S_CKE_WAIT: if (zero) nxt = S_XPR;
            S_XPR:      if (zero) nxt = S_MRS;
            S_MRS: begin
                mr_nxt = mr_idx + 2'd1;
                nxt = (mr_idx == 2'd3) ? ((cyc(T_MOD_CYC) > 1) ? S_WAIT_MOD : S_ZQCL)
                                       : ((cyc(T_MRD_CYC) > 1) ? S_WAIT_MRD : S_MRS);
            end
            S_WAIT_MRD: if (zero) nxt = S_MRS;
            S_WAIT_MOD: if (zero) nxt = S_ZQCL;
            S_ZQCL:     nxt = (cyc(T_ZQINIT_CYC) > 1) ? S_WAIT_ZQ : S_DONE;
            S_WAIT_ZQ:  if (zero) nxt = S_DONE;
`ifdef DDR3_AUTO_REFRESH_EN
            S_DONE:     if (ref_req && ref_ack) nxt = S_PRE;
            S_PRE:      nxt = (cyc(T_RP_CYC) > 1) ? S_WAIT_RP : S_REF;
            S_WAIT_RP:  if (zero) nxt = S_REF;
            S_REF:      nxt = (cyc(T_RFC_CYC) > 1) ? S_WAIT_RFC : S_DONE;
            S_WAIT_RFC: if (zero) nxt = S_DONE;
`endif
            default: ;
        endcase
        // back-to-back MRS re-enters the same state, so it must reload too
        load = (nxt != state) || (state == S_MRS);
        case (nxt)
            S_RST_HOLD: lval = CW'(cyc(T_RESET_CYC) - 1);
            S_CKE_WAIT: lval = CW'(cyc(T_CKE_CYC) - 1);
            S_XPR:      lval = CW'(cyc(T_XPR_CYC) - 1);
            S_WAIT_MRD: lval = CW'(cyc(T_MRD_CYC) - 2);
            S_WAIT_MOD: lval = CW'(cyc(T_MOD_CYC) - 2);
            S_WAIT_ZQ:  lval = CW'(cyc(T_ZQINIT_CYC) - 2);
`ifdef DDR3_AUTO_REFRESH_EN
            S_WAIT_RP:  lval = CW'(cyc(T_RP_CYC) - 2);
            S_WAIT_RFC: lval = CW'(cyc(T_RFC_CYC) - 2);
`endif
            default:    lval = '0;
        endcase
        mem_rst_d = !(nxt inside {S_IDLE, S_RST_HOLD});
        cke_d = !(nxt inside {S_IDLE, S_RST_HOLD, S_CKE_WAIT});
        done_d = nxt inside {S_DONE, S_PRE, S_WAIT_RP, S_REF, S_WAIT_RFC};
        mr_sel = mr_num(mr_nxt);
        cmd_d = cke_d ? CMD_NOP : CMD_DES;
        ba_d = '0;
        addr_d = '0;
        case (nxt)
            S_MRS: begin
                cmd_d = CMD_MRS;
                ba_d = BA_BITS'(mr_sel);
                addr_d = (mr_sel == 2'd0) ? MR0_VAL : (mr_sel == 2'd1) ? MR1_VAL :
                         (mr_sel == 2'd2) ? MR2_VAL : MR3_VAL;
            end
            S_ZQCL: begin
                cmd_d = CMD_ZQCL;
                addr_d = A10;
            end
            S_PRE: begin
                cmd_d = CMD_PRE;
                addr_d = A10;
            end
            S_REF: cmd_d = CMD_REF;
            default: ;
        endcase
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            mr_idx <= '0;
            {cs_n, ras_n, cas_n, we_n} <= CMD_DES;
            mem_rst_n <= 1'b0;
            cke <= 1'b0;
            ba <= '0;
            addr <= '0;
            odt <= 1'b0;
            init_done <= 1'b0;
            busy <= 1'b0;
        end else begin
            state <= nxt;
            mr_idx <= mr_nxt;
            {cs_n, ras_n, cas_n, we_n} <= cmd_d;
            mem_rst_n <= mem_rst_d;
            cke <= cke_d;
            ba <= ba_d;
            addr <= addr_d;
            odt <= 1'b0;
            init_done <= done_d;
            busy <= (nxt != S_IDLE) && !done_d;
        end
    end

`ifdef DDR3_AUTO_REFRESH_EN
    logic izero, iload, ref_req_d;

    // interval restarts on every DONE entry: after init and after each refresh
    assign iload = (nxt == S_DONE) && (state != S_DONE);
    assign ref_req_d = (nxt inside {S_PRE, S_WAIT_RP, S_REF, S_WAIT_RFC}) ||
                       ((nxt == S_DONE) && (state == S_DONE) && (ref_req || izero));

    ddr3_wait_cnt #(.W(CW)) u_refi (
        .ck, .rst_n, .load(iload), .load_val(CW'(cyc(T_REFI_CYC) - 1)), .zero(izero)
    );

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) ref_req <= 1'b0;
        else ref_req <= ref_req_d;
    end
`else
    logic unused_ref_ack;

    assign unused_ref_ack = ref_ack;
    assign ref_req = 1'b0;
`endif

endmodule

// File: tb/tb_ddr3_init_seq.sv
// tb_ddr3_init_seq: bench for ddr3_init_seq with an event-time model of the init sequence.
module tb_ddr3_init_seq;
    localparam int TR = 10, TC = 20, TX = 5, TM = 4, TMOD = 12, TZ = 8;
`ifdef DDR3_AUTO_REFRESH_EN
    localparam int TREFI = 50, TRP = 3, TRFC = 6, ACK_DLY = 4;
`endif

    logic ck = 1'b0, rst_n = 1'b0, start = 1'b0, ref_ack = 1'b0;
    logic init_done, busy, mem_rst_n, cke, cs_n, ras_n, cas_n, we_n, odt, ref_req;
    logic [2:0] ba;
    logic [13:0] addr;
    int edges = 0, start_e = 0, total = 0, bad = 0;
    bit started = 0, chk_on = 0;
    logic [13:0] mrv [4] = '{14'h0520, 14'h0044, 14'h0008, 14'h0000};
    int mr_ord [4] = '{2, 3, 1, 0};
    logic [26:0] idle_pins;

    ddr3_init_seq #(
        .T_RESET_CYC(TR), .T_CKE_CYC(TC), .T_XPR_CYC(TX), .T_MRD_CYC(TM), .T_MOD_CYC(TMOD),
        .T_ZQINIT_CYC(TZ), .MR0_VAL(14'h0520), .MR1_VAL(14'h0044), .MR2_VAL(14'h0008),
        .MR3_VAL(14'h0000)
`ifdef DDR3_AUTO_REFRESH_EN
        , .T_REFI_CYC(TREFI), .T_RP_CYC(TRP), .T_RFC_CYC(TRFC)
`endif
    ) dut (
        .ck(ck), .rst_n(rst_n), .start(start), .init_done(init_done), .busy(busy),
        .mem_rst_n(mem_rst_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
        .we_n(we_n), .ba(ba), .addr(addr), .odt(odt), .ref_req(ref_req), .ref_ack(ref_ack)
    );

    wire [26:0] pins = {ref_req, init_done, busy, mem_rst_n, cke, odt, cs_n, ras_n, cas_n, we_n, ba, addr};
    wire [3:0] cmd = {cs_n, ras_n, cas_n, we_n};

    always #5 ck = ~ck;
    always @(posedge ck) edges <= edges + 1;

    initial idle_pins = {6'b000000, 4'b1111, 3'd0, 14'd0};

    // expected pins k cycles after the start edge, from the event times of the sequence
    function automatic logic [26:0] model(int k);
        logic [3:0] c;
        logic [2:0] b;
        logic [13:0] a;
        logic rr, rs, ce, dn;
        int m0, zq, dk;
        if (!started) return idle_pins;
        m0 = TR + TC + TX;
        zq = m0 + 3 * TM + TMOD;
        dk = zq + TZ;
        rs = k >= TR;
        ce = k >= TR + TC;
        dn = k >= dk;
        c = ce ? 4'b0111 : 4'b1111;
        b = 3'd0;
        a = 14'd0;
        rr = 1'b0;
        for (int i = 0; i < 4; i++)
            if (k == m0 + i * TM) begin
                c = 4'b0000;
                b = 3'(mr_ord[i]);
                a = mrv[mr_ord[i]];
            end
        if (k == zq) begin
            c = 4'b0110;
            a = 14'h0400;
        end
`ifdef DDR3_AUTO_REFRESH_EN
        begin
            int rq, pre, rf, drop;
            rq = dk + TREFI;
            pre = rq + ACK_DLY + 1;
            rf = pre + TRP;
            drop = rf + TRFC;
            rr = (k >= rq) && (k < drop);
            if (k == pre) begin
                c = 4'b0010;
                a = 14'h0400;
            end
            if (k == rf) c = 4'b0001;
        end
`endif
        return {rr, dn, !dn, rs, ce, 1'b0, c, b, a};
    endfunction

    task automatic chk(string name, int k, logic [26:0] got, logic [26:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s k=%0d got=%h want=%h", name, k, got, want);
        end
    endtask

    task automatic wait_k(int k);
        while (edges - start_e < k) @(negedge ck);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        start_e = edges + 1;
        started = 1;
        @(negedge ck);
        start = 1'b0;
    endtask

    task automatic poke_start();
        start = 1'b1;
        @(negedge ck);
        start = 1'b0;
    endtask

    always @(posedge ck) begin
        #2;
        if (chk_on) chk("pins", edges - start_e, pins, model(edges - start_e));
    end

    initial begin
        #100000;
        $display("FAIL watchdog k=%0d", edges - start_e);
        $fatal(1);
    end

    initial begin
        #23;
        chk("reset", 0, pins, idle_pins);
        @(negedge ck);
        rst_n = 1'b1;
        chk_on = 1;
        repeat (3) @(negedge ck);
        pulse_start();
        wait_k(9);  chk("mem_rst_low", 9, 27'(mem_rst_n), 27'd0);
        wait_k(10); chk("mem_rst_rise", 10, 27'(mem_rst_n), 27'd1);
        wait_k(29); chk("cke_low", 29, 27'(cke), 27'd0);
        wait_k(30); chk("cke_rise", 30, 27'(cke), 27'd1);
        wait_k(32); poke_start();
        wait_k(35); chk("mr2", 35, 27'({cmd, ba, addr}), 27'({4'b0000, 3'd2, 14'h0008}));
        wait_k(39); chk("mr3", 39, 27'({cmd, ba, addr}), 27'({4'b0000, 3'd3, 14'h0000}));
        wait_k(43); chk("mr1", 43, 27'({cmd, ba, addr}), 27'({4'b0000, 3'd1, 14'h0044}));
        wait_k(47); chk("mr0", 47, 27'({cmd, ba, addr}), 27'({4'b0000, 3'd0, 14'h0520}));
        wait_k(59); chk("zqcl", 59, 27'({cmd, addr}), 27'({4'b0110, 14'h0400}));
        wait_k(66); chk("busy_pre_done", 66, 27'({init_done, busy}), 27'b01);
        wait_k(67); chk("init_done", 67, 27'({init_done, busy}), 27'b10);
        wait_k(70); poke_start();
`ifdef DDR3_AUTO_REFRESH_EN
        for (int i = 0; i < 200 && !ref_req; i++) @(negedge ck);
        chk("ref_req_rise", 0, 27'(edges - start_e), 27'd117);
        repeat (ACK_DLY) @(negedge ck);
        ref_ack = 1'b1;
        @(negedge ck);
        ref_ack = 1'b0;
        chk("pre_all", edges - start_e, 27'({cmd, addr}), 27'({4'b0010, 14'h0400}));
        wait_k(125); chk("ref_cmd", 125, 27'(cmd), 27'(4'b0001));
        wait_k(130); chk("ref_req_hold", 130, 27'(ref_req), 27'd1);
        wait_k(131); chk("ref_req_drop", 131, 27'(ref_req), 27'd0);
        wait_k(140);
`else
        wait_k(90); chk("ref_req_tied", 90, 27'(ref_req), 27'd0);
`endif
        chk_on = 0;
        rst_n = 1'b0;
        started = 0;
        @(negedge ck);
        rst_n = 1'b1;
        chk_on = 1;
        @(negedge ck);
        pulse_start();
        wait_k(40);
        chk_on = 0;
        #2;
        rst_n = 1'b0;
        started = 0;
        #1;
        chk("async_rst", 40, pins, idle_pins);
        @(negedge ck);
        rst_n = 1'b1;
        chk_on = 1;
        repeat (100) @(negedge ck);
        chk("idle_after_rst", 100, pins, idle_pins);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
